// File: rtl/mem_pkg.sv
// Shared definitions for the data_memory_pipe block.
//   state_t               : control FSM states (IDLE, WAIT, RESP, CLEAR)
//   LATENCY_MIN/MAX       : legal bounds of the response latency parameter
//   width_min1()          : $clog2 helper that never returns a zero width
package mem_pkg;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RESP  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  // Counter widths must be at least one bit even when the counted range
  // collapses to a single value (LATENCY=1 or DEPTH=1).
  function automatic int width_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/mem_array_bytewise.sv
// Word-organised storage with per-byte write enables.
//   clk    : clock, writes and read capture on the rising edge
//   we     : write enable; waddr/wdata/wstrb select word, data and bytes
//   re     : read capture enable; rdata <= word at raddr, then held
//   rdata  : last captured word
// Contents start at zero and are never touched by any reset.
module mem_array_bytewise #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic                clk,
  input  logic                we,
  input  logic [IDX_W-1:0]    waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                re,
  input  logic [IDX_W-1:0]    raddr,
  output logic [DATA_W-1:0]   rdata
);

  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  // Only one request is in flight, so a read capture and a request write
  // never share an edge; a read therefore always sees completed writes.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/data_memory_pipe.sv
// Single-outstanding request memory with fixed response latency and a
// sequential clear sweep.
//   clk, rst                 : clock, asynchronous active-high reset
//   req_valid/req_ready      : request handshake
//   req_write/addr/wdata/wstrb : request payload (addr is a word index)
//   resp_valid               : one-cycle response strobe, LATENCY cycles
//                              after acceptance
//   resp_rdata/resp_err      : response payload, zero unless resp_valid
//   clear_start/clear_busy   : start and progress of the zeroing sweep
//   dbg_state                : current FSM state
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE with no
// clear_start and no reset. The response cannot be stalled.
module data_memory_pipe
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 64,
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  input  logic                clear_start,
  output logic                clear_busy,
  output state_t              dbg_state
);

  localparam int IDX_W  = width_min1(DEPTH);
  localparam int WAIT_W = width_min1(LATENCY);
  localparam int STRB_W = DATA_W / 8;

  localparam logic [IDX_W-1:0]  CLR_LAST  = IDX_W'(DEPTH - 1);
  // WAIT lasts LATENCY-1 cycles: counter values 0 .. LATENCY-2.
  localparam logic [WAIT_W-1:0] WAIT_LAST = (LATENCY > 1) ? WAIT_W'(LATENCY - 2) : '0;

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("data_memory_pipe: LATENCY out of range");
  end

  state_t             state, state_nx;
  logic [IDX_W-1:0]   clr_cnt, clr_cnt_nx;
  logic [WAIT_W-1:0]  wait_cnt, wait_cnt_nx;
  logic               resp_rd_q;   // response carries array read data
  logic               resp_err_q;  // response flags an address error

  logic               accept;
  logic               addr_err;
  logic [IDX_W-1:0]   idx;

  logic               arr_we;
  logic [IDX_W-1:0]   arr_waddr;
  logic [DATA_W-1:0]  arr_wdata;
  logic [STRB_W-1:0]  arr_wstrb;
  logic               arr_re;
  logic [DATA_W-1:0]  arr_rdata;

  // Any high address bit pushes the value past DEPTH, so one compare on
  // the full width covers both the range check and stray upper bits.
  assign addr_err  = (req_addr >= ADDR_W'(DEPTH));
  assign idx       = req_addr[IDX_W-1:0];

  assign req_ready = (state == IDLE) && !clear_start && !rst;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    clr_cnt_nx  = clr_cnt;
    case (state)
      IDLE: begin
        wait_cnt_nx = '0;
        clr_cnt_nx  = '0;
        if (clear_start) begin
          state_nx = CLEAR;
        end else if (accept) begin
          state_nx = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_nx = RESP;
        end else begin
          wait_cnt_nx = wait_cnt + 1'b1;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      CLEAR: begin
        if (clr_cnt == CLR_LAST) begin
          state_nx   = IDLE;
          clr_cnt_nx = '0;
        end else begin
          clr_cnt_nx = clr_cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      clr_cnt    <= '0;
      resp_rd_q  <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      clr_cnt  <= clr_cnt_nx;
      if (accept) begin
        resp_rd_q  <= !req_write && !addr_err;
        resp_err_q <= addr_err;
      end
    end
  end

  // The sweep owns the write port while in CLEAR; requests cannot be
  // accepted then, so there is no contention.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = idx;
    arr_wdata = req_wdata;
    arr_wstrb = req_wstrb;
    if (state == CLEAR) begin
      arr_we    = 1'b1;
      arr_waddr = clr_cnt;
      arr_wdata = '0;
      arr_wstrb = '1;
    end else if (accept && req_write && !addr_err) begin
      arr_we = 1'b1;
    end
  end

  assign arr_re = accept && !req_write && !addr_err;

  mem_array_bytewise #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .wstrb (arr_wstrb),
    .re    (arr_re),
    .raddr (idx),
    .rdata (arr_rdata)
  );

  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid && resp_err_q;
  assign resp_rdata = (resp_valid && resp_rd_q) ? arr_rdata : '0;
  assign clear_busy = (state == CLEAR);
  assign dbg_state  = state;

endmodule

// File: tb/tb_data_memory_pipe.sv
// Bench for data_memory_pipe: three instances with different geometry
//   0: DEPTH=1024 LATENCY=1   1: DEPTH=1024 LATENCY=3   2: DEPTH=16 LATENCY=4
module tb_data_memory_pipe;
  import mem_pkg::*;

  localparam int N = 3;
  localparam int DEPTHS [N] = '{1024, 1024, 16};
  localparam int LATS   [N] = '{1, 3, 4};

  logic        clk;
  logic        rst         [N];
  logic        req_valid   [N];
  logic        req_ready   [N];
  logic        req_write   [N];
  logic [63:0] req_addr    [N];
  logic [31:0] req_wdata   [N];
  logic [3:0]  req_wstrb   [N];
  logic        resp_valid  [N];
  logic [31:0] resp_rdata  [N];
  logic        resp_err    [N];
  logic        clear_start [N];
  logic        clear_busy  [N];
  state_t      dbg_state   [N];

  int passed = 0;
  int total  = 0;

  logic [31:0] mdl [N][1024];
  logic [31:0] exp_q [$];

  data_memory_pipe #(.DATA_W(32), .DEPTH(1024), .ADDR_W(64), .LATENCY(1)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_wstrb(req_wstrb[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .clear_start(clear_start[0]), .clear_busy(clear_busy[0]),
    .dbg_state(dbg_state[0]));

  data_memory_pipe #(.DATA_W(32), .DEPTH(1024), .ADDR_W(64), .LATENCY(3)) u_dut1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_wstrb(req_wstrb[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .clear_start(clear_start[1]), .clear_busy(clear_busy[1]),
    .dbg_state(dbg_state[1]));

  data_memory_pipe #(.DATA_W(32), .DEPTH(16), .ADDR_W(64), .LATENCY(4)) u_dut2 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .req_wstrb(req_wstrb[2]), .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]),
    .resp_err(resp_err[2]), .clear_start(clear_start[2]), .clear_busy(clear_busy[2]),
    .dbg_state(dbg_state[2]));

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: addresses beyond the depth are errors with no access;
  // writes merge enabled bytes; reads return the stored word.
  task automatic model_access(input int s, input logic w, input logic [63:0] a,
                              input logic [31:0] d, input logic [3:0] st,
                              output logic [31:0] rd, output logic er);
    rd = '0;
    er = 1'b0;
    if (a >= 64'(DEPTHS[s])) begin
      er = 1'b1;
    end else if (w) begin
      for (int b = 0; b < 4; b++)
        if (st[b]) mdl[s][int'(a)][b*8 +: 8] = d[b*8 +: 8];
    end else begin
      rd = mdl[s][int'(a)];
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input int s, input logic w, input logic [63:0] a,
                        input logic [31:0] d, input logic [3:0] st,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic ok_ready, output logic ok_pulse);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready[s] && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_valid[s] = 1'b1;
    req_write[s] = w;
    req_addr[s]  = a;
    req_wdata[s] = d;
    req_wstrb[s] = st;
    @(posedge clk);
    #1;
    req_valid[s] = 1'b0;
    rd = '0; er = 1'b0; lat = 0; ok_ready = 1'b1; ok_pulse = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (req_ready[s]) ok_ready = 1'b0;
      if (resp_valid[s]) begin
        lat = i;
        rd  = resp_rdata[s];
        er  = resp_err[s];
        break;
      end
      if (resp_rdata[s] !== '0 || resp_err[s] !== 1'b0) ok_pulse = 1'b0;
    end
    @(negedge clk);
    if (resp_valid[s] || resp_rdata[s] !== '0 || resp_err[s] !== 1'b0) ok_pulse = 1'b0;
  endtask

  typedef struct {
    int          s;
    logic        w;
    logic [63:0] a;
    logic [31:0] d;
    logic [3:0]  st;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic [31:0] rd, m_rd;
    logic        er, m_er, okr, okp, seen;
    int          lat, cnt, bad;

    for (int s = 0; s < N; s++) begin
      rst[s] = 1'b1; req_valid[s] = 1'b0; req_write[s] = 1'b0; req_addr[s] = '0;
      req_wdata[s] = '0; req_wstrb[s] = '0; clear_start[s] = 1'b0;
      for (int a = 0; a < 1024; a++) mdl[s][a] = '0;
    end

    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    for (int s = 0; s < N; s++) begin
      check($sformatf("rst_busy%0d", s), 64'(clear_busy[s]), 64'd0);
      check($sformatf("rst_rvalid%0d", s), 64'(resp_valid[s]), 64'd0);
    end
    for (int s = 0; s < N; s++) rst[s] = 1'b0;
    #1;
    for (int s = 0; s < N; s++) begin
      check($sformatf("rst_ready%0d", s), 64'(req_ready[s]), 64'd1);
      check($sformatf("rst_rdata%0d", s), 64'(resp_rdata[s]), 64'd0);
      check($sformatf("rst_err%0d", s), 64'(resp_err[s]), 64'd0);
      check($sformatf("rst_state%0d", s), 64'(dbg_state[s] == IDLE), 64'd1);
    end

    // ---------------- directed vector table ----------------
    vecs[0]  = '{0, 1'b1, 64'd0,          32'd1000,       4'hF, 32'd0,          1'b0};
    vecs[1]  = '{0, 1'b0, 64'd0,          32'd0,          4'h0, 32'd1000,       1'b0};
    vecs[2]  = '{1, 1'b1, 64'd5,          32'hAABBCCDD,   4'hF, 32'd0,          1'b0};
    vecs[3]  = '{1, 1'b1, 64'd5,          32'h11223344,   4'h5, 32'd0,          1'b0};
    vecs[4]  = '{1, 1'b0, 64'd5,          32'd0,          4'h0, 32'hAA22CC44,   1'b0};
    vecs[5]  = '{1, 1'b0, 64'd1024,       32'd0,          4'h0, 32'd0,          1'b1};
    vecs[6]  = '{1, 1'b0, 64'd1 << 40,    32'd0,          4'h0, 32'd0,          1'b1};
    vecs[7]  = '{1, 1'b1, 64'd1029,       32'hFFFFFFFF,   4'hF, 32'd0,          1'b1};
    vecs[8]  = '{1, 1'b0, 64'd5,          32'd0,          4'h0, 32'hAA22CC44,   1'b0};
    vecs[9]  = '{1, 1'b0, 64'd0,          32'd0,          4'h0, 32'd0,          1'b0};
    vecs[10] = '{2, 1'b1, 64'd15,         32'h12345678,   4'hF, 32'd0,          1'b0};
    vecs[11] = '{2, 1'b0, 64'd16,         32'd0,          4'h0, 32'd0,          1'b1};
    vecs[12] = '{2, 1'b0, 64'd15,         32'd0,          4'h0, 32'h12345678,   1'b0};

    for (int i = 0; i < 13; i++) begin
      model_access(vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].st, m_rd, m_er);
      do_req(vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].st, rd, er, lat, okr, okp);
      check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
      check($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(LATS[vecs[i].s]));
      check($sformatf("vec%0d_ready_low", i), 64'(okr), 64'd1);
      check($sformatf("vec%0d_pulse", i), 64'(okp), 64'd1);
    end

    // ---------------- randomized traffic vs model ----------------
    for (int s = 0; s < N; s++) begin
      for (int k = 0; k < 40; k++) begin
        logic        w;
        logic [63:0] a;
        logic [31:0] d;
        logic [3:0]  st;
        w  = 1'($urandom_range(0, 1));
        a  = ($urandom_range(0, 9) == 0) ? 64'(DEPTHS[s] + $urandom_range(0, 5))
                                          : 64'($urandom_range(0, 7));
        d  = $urandom;
        st = 4'($urandom_range(0, 15));
        model_access(s, w, a, d, st, m_rd, m_er);
        exp_q.push_back(m_rd);
        do_req(s, w, a, d, st, rd, er, lat, okr, okp);
        check($sformatf("rnd%0d_%0d_rdata", s, k), 64'(rd), 64'(exp_q.pop_front()));
        check($sformatf("rnd%0d_%0d_err", s, k), 64'(er), 64'(m_er));
        check($sformatf("rnd%0d_%0d_latency", s, k), 64'(lat), 64'(LATS[s]));
      end
    end

    // ---------------- clear beats a simultaneous request ----------------
    do_req(1, 1'b1, 64'd1023, 32'hCAFEF00D, 4'hF, rd, er, lat, okr, okp);
    @(negedge clk);
    clear_start[1] = 1'b1;
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 64'd7;
    req_wdata[1] = 32'hDEADBEEF; req_wstrb[1] = 4'hF;
    #1;
    check("clr_ready_low", 64'(req_ready[1]), 64'd0);
    @(posedge clk);
    #1;
    clear_start[1] = 1'b0;
    req_valid[1] = 1'b0;
    cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (resp_valid[1]) seen = 1'b1;
      if (!clear_busy[1]) break;
      cnt++;
    end
    repeat (6) begin
      @(negedge clk);
      if (resp_valid[1]) seen = 1'b1;
    end
    check("clr_busy_cycles", 64'(cnt), 64'd1024);
    check("clr_no_resp", 64'(seen), 64'd0);
    for (int a = 0; a < 1024; a++) mdl[1][a] = '0;
    bad = 0;
    for (int a = 0; a < 1024; a++) begin
      do_req(1, 1'b0, 64'(a), 32'd0, 4'h0, rd, er, lat, okr, okp);
      if (rd !== mdl[1][a] || er !== 1'b0) bad++;
    end
    check("clr_readback_bad", 64'(bad), 64'd0);

    // ---------------- reset drops a pending response ----------------
    @(negedge clk);
    req_valid[2] = 1'b1; req_write[2] = 1'b0; req_addr[2] = 64'd3;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst[2] = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid[2]) seen = 1'b1;
    end
    rst[2] = 1'b0;
    #1;
    check("rst_mid_ready", 64'(req_ready[2]), 64'd1);
    repeat (8) begin
      @(negedge clk);
      if (resp_valid[2]) seen = 1'b1;
    end
    check("rst_mid_no_resp", 64'(seen), 64'd0);

    // ---------------- reset aborts a clear sweep ----------------
    for (int a = 0; a < 16; a++) begin
      model_access(2, 1'b1, 64'(a), 32'hFFFFFFFF, 4'hF, m_rd, m_er);
      do_req(2, 1'b1, 64'(a), 32'hFFFFFFFF, 4'hF, rd, er, lat, okr, okp);
    end
    @(negedge clk);
    clear_start[2] = 1'b1;
    @(posedge clk);
    #1;
    clear_start[2] = 1'b0;
    check("abort_busy", 64'(clear_busy[2]), 64'd1);
    repeat (8) @(posedge clk);
    #1;
    rst[2] = 1'b1;
    #1;
    check("abort_busy_rst", 64'(clear_busy[2]), 64'd0);
    for (int a = 0; a < 8; a++) mdl[2][a] = '0;
    repeat (2) @(negedge clk);
    rst[2] = 1'b0;
    for (int a = 0; a < 16; a++) begin
      do_req(2, 1'b0, 64'(a), 32'd0, 4'h0, rd, er, lat, okr, okp);
      check($sformatf("abort_rd%0d", a), 64'(rd), 64'(mdl[2][a]));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
